// File: rtl/sipo_loader_if.sv
// Serial frame input and assembled-word output bundle for sipo_loader.
// Latency: none, wires only.
// Backpressure: none; the serial source is paced only by sdi_valid.
interface sipo_loader_if #(
  parameter int W = 16
);
  logic         sof;
  logic         sdi;
  logic         sdi_valid;
  logic [W-1:0] d;
  logic         load;
  logic         busy;
  logic         err;
  logic [7:0]   err_cnt;

  // Serial source side
  modport master (
    output sof, sdi, sdi_valid,
    input  d, load, busy, err, err_cnt
  );

  // Word assembler side
  modport slave (
    input  sof, sdi, sdi_valid,
    output d, load, busy, err, err_cnt
  );
endinterface

// File: rtl/sipo_loader.sv
// Serial-in/parallel-out word assembler feeding dreg; drops and counts aborted frames.
// Latency: load and d appear 1 cycle after the edge that samples the last bit.
// Backpressure: none; bits are taken on every sdi_valid cycle, stalls only time out.
module sipo_loader #(
  parameter int W         = 16,
  parameter bit MSB_FIRST = 1'b1,
  parameter int TIMEOUT   = 64
) (
  input  logic          clk50m,
  input  logic          rst,
  sipo_loader_if.slave  bus
);

  localparam int CW = $clog2(W + 1);
  localparam int IW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(W - 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    sr_q, sr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]   idle_q, idle_d;
  logic [W-1:0]    word_q, word_d;
  logic            load_q, load_d;
  logic            err_q, err_d;
  logic [7:0]      err_cnt_q, err_cnt_d;

  logic            start;
  logic            take;
  logic            complete;
  logic            early;
  logic            timeout;
  logic            abort;
  logic            busy;
  logic [W-1:0]    shifted;

  // Classify this cycle: frame start, continuing bit, completion, or abort
  always_comb begin
    start    = bus.sdi_valid && bus.sof;
    take     = bus.sdi_valid && !bus.sof && (state_q == SHIFT);
    complete = take && (cnt_q == CNT_LAST);
    early    = start && (state_q == SHIFT);
    timeout  = (TIMEOUT > 0) && (state_q == SHIFT) && !bus.sdi_valid && (idle_q == IDLE_LAST);
    abort    = early || timeout;
    shifted  = MSB_FIRST ? {sr_q[W-2:0], bus.sdi} : {bus.sdi, sr_q[W-1:1]};
  end

  // State register and datapath flops; reset discards any partial frame
  always_ff @(posedge clk50m) begin
    if (rst) begin
      state_q   <= IDLE;
      sr_q      <= '0;
      cnt_q     <= '0;
      idle_q    <= '0;
      word_q    <= '0;
      load_q    <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      cnt_q     <= cnt_d;
      idle_q    <= idle_d;
      word_q    <= word_d;
      load_q    <= load_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  // Next state: any sof starts/restarts a frame; last bit or stall returns to IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (complete || timeout) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values: shifting, bit/idle counting, word capture, error count
  always_comb begin
    sr_d      = sr_q;
    cnt_d     = cnt_q;
    idle_d    = idle_q;
    word_d    = word_q;
    load_d    = 1'b0;
    err_d     = abort;
    err_cnt_d = err_cnt_q;
    if (start) begin
      // sof bit is bit 1 of a fresh frame; older bits shift out before completion
      sr_d   = shifted;
      cnt_d  = CW'(1);
      idle_d = '0;
    end else if (take) begin
      sr_d   = shifted;
      cnt_d  = cnt_q + CW'(1);
      idle_d = '0;
      if (complete) begin
        word_d = shifted;
        load_d = 1'b1;
        cnt_d  = '0;
      end
    end else if (state_q == SHIFT) begin
      if (timeout) begin
        idle_d = '0;
        cnt_d  = '0;
      end else if (TIMEOUT > 0) begin
        idle_d = idle_q + IW'(1);
      end
    end
    if (abort && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
  end

  // Outputs: busy decoded from state, everything else straight from flops
  always_comb begin
    busy = (state_q == SHIFT);
  end

  assign bus.d       = word_q;
  assign bus.load    = load_q;
  assign bus.busy    = busy;
  assign bus.err     = err_q;
  assign bus.err_cnt = err_cnt_q;

endmodule

// File: tb/tb_sipo_loader.sv
// Directed bench for sipo_loader: MSB-first and LSB-first instances share one stimulus.
// Latency: checks sample 1 time unit after each rising edge.
// Backpressure: none; stimulus drives sdi_valid directly.
module tb_sipo_loader;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sof = 1'b0;
  logic sdi = 1'b0;
  logic vld = 1'b0;

  int passes = 0;
  int total  = 0;
  int load_seen = 0;
  int err_seen  = 0;
  int both_seen = 0;
  int base_load;
  int base_err;

  always #10 clk = ~clk;

  sipo_loader_if #(.W(16)) bus_m ();
  sipo_loader_if #(.W(16)) bus_l ();

  assign bus_m.sof = sof;
  assign bus_m.sdi = sdi;
  assign bus_m.sdi_valid = vld;
  assign bus_l.sof = sof;
  assign bus_l.sdi = sdi;
  assign bus_l.sdi_valid = vld;

  sipo_loader #(.W(16), .MSB_FIRST(1'b1), .TIMEOUT(8)) dut_m (
    .clk50m (clk),
    .rst    (rst),
    .bus    (bus_m)
  );

  sipo_loader #(.W(16), .MSB_FIRST(1'b0), .TIMEOUT(8)) dut_l (
    .clk50m (clk),
    .rst    (rst),
    .bus    (bus_l)
  );

  // Pulse counters for the MSB-first instance, sampled mid-cycle
  always @(negedge clk) begin
    if (bus_m.load) load_seen++;
    if (bus_m.err) err_seen++;
    if (bus_m.load && bus_m.err) both_seen++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passes++;
    end else begin
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      sof = 1'b0; sdi = 1'b0; vld = 1'b0;
      tick();
    end
  endtask

  // Sends one full frame, MSB of w first; gap idle cycles before each later bit
  task automatic send_word(input logic [15:0] w, input int gap);
    for (int i = 0; i < 16; i++) begin
      if (i > 0) begin
        for (int g = 0; g < gap; g++) begin
          sof = 1'b0; sdi = 1'b0; vld = 1'b0;
          tick();
          chk("gap_busy", 32'(bus_m.busy), 32'd1);
        end
      end
      sof = (i == 0); sdi = w[15-i]; vld = 1'b1;
      tick();
      if (i < 15) begin
        chk("frame_busy", 32'(bus_m.busy), 32'd1);
        chk("frame_noload", 32'(bus_m.load), 32'd0);
      end
    end
    sof = 1'b0; sdi = 1'b0; vld = 1'b0;
  endtask

  // Sends n bits with sof on the first one (bit values alternate 1,0,...)
  task automatic send_bits(input int n);
    for (int i = 0; i < n; i++) begin
      sof = (i == 0); sdi = ~i[0]; vld = 1'b1;
      tick();
    end
    sof = 1'b0; sdi = 1'b0; vld = 1'b0;
  endtask

  initial begin
    // Reset state
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_d", 32'(bus_m.d), 32'h0);
    chk("rst_load", 32'(bus_m.load), 32'd0);
    chk("rst_busy", 32'(bus_m.busy), 32'd0);
    chk("rst_err", 32'(bus_m.err), 32'd0);
    chk("rst_errcnt", 32'(bus_m.err_cnt), 32'd0);

    // IDLE: valid bits without sof are discarded silently
    sdi = 1'b1; vld = 1'b1;
    tick();
    tick();
    vld = 1'b0;
    chk("idle_nobusy", 32'(bus_m.busy), 32'd0);
    chk("idle_noerr", 32'(bus_m.err), 32'd0);

    // 1: back-to-back bits of AAFF
    base_load = load_seen;
    send_word(16'hAAFF, 0);
    chk("t1_load", 32'(bus_m.load), 32'd1);
    chk("t1_d", 32'(bus_m.d), 32'h0000AAFF);
    chk("t1_d_lsb", 32'(bus_l.d), 32'h0000FF55);
    chk("t1_busy", 32'(bus_m.busy), 32'd0);
    chk("t1_errcnt", 32'(bus_m.err_cnt), 32'd0);
    idle(1);
    chk("t1_load_off", 32'(bus_m.load), 32'd0);
    chk("t1_d_hold", 32'(bus_m.d), 32'h0000AAFF);
    chk("t1_loads", 32'(load_seen - base_load), 32'd1);

    // 2: FFAA with sdi_valid low every other cycle
    base_load = load_seen;
    send_word(16'hFFAA, 1);
    chk("t2_load", 32'(bus_m.load), 32'd1);
    chk("t2_d", 32'(bus_m.d), 32'h0000FFAA);
    chk("t2_busy", 32'(bus_m.busy), 32'd0);
    idle(2);
    chk("t2_loads", 32'(load_seen - base_load), 32'd1);

    // 3: 5 bits, then sof restarts with a full 0000 frame
    base_load = load_seen;
    base_err  = err_seen;
    send_bits(5);
    chk("t3_partial_busy", 32'(bus_m.busy), 32'd1);
    sof = 1'b1; sdi = 1'b0; vld = 1'b1;
    tick();
    chk("t3_err_pulse", 32'(bus_m.err), 32'd1);
    chk("t3_errcnt", 32'(bus_m.err_cnt), 32'd1);
    chk("t3_d_unchanged", 32'(bus_m.d), 32'h0000FFAA);
    for (int i = 1; i < 16; i++) begin
      sof = 1'b0; sdi = 1'b0; vld = 1'b1;
      tick();
    end
    vld = 1'b0;
    chk("t3_load", 32'(bus_m.load), 32'd1);
    chk("t3_d", 32'(bus_m.d), 32'h0);
    idle(2);
    chk("t3_loads", 32'(load_seen - base_load), 32'd1);
    chk("t3_errs", 32'(err_seen - base_err), 32'd1);

    // 4: timeout after 8 idle cycles; 7 idle cycles then a bit survives
    base_load = load_seen;
    base_err  = err_seen;
    send_bits(3);
    idle(7);
    chk("t4_busy_at7", 32'(bus_m.busy), 32'd1);
    chk("t4_noerr_at7", 32'(bus_m.err), 32'd0);
    idle(1);
    chk("t4_err", 32'(bus_m.err), 32'd1);
    chk("t4_busy", 32'(bus_m.busy), 32'd0);
    chk("t4_noload", 32'(bus_m.load), 32'd0);
    chk("t4_d_kept", 32'(bus_m.d), 32'h0);
    chk("t4_errcnt", 32'(bus_m.err_cnt), 32'd2);
    idle(1);
    chk("t4_err_off", 32'(bus_m.err), 32'd0);
    send_bits(3);
    idle(7);
    sof = 1'b0; sdi = 1'b1; vld = 1'b1;
    tick();
    chk("t4_saved_busy", 32'(bus_m.busy), 32'd1);
    chk("t4_saved_noerr", 32'(bus_m.err), 32'd0);
    idle(7);
    chk("t4_idle_restart", 32'(bus_m.busy), 32'd1);
    chk("t4_errs", 32'(err_seen - base_err), 32'd1);
    chk("t4_loads", 32'(load_seen - base_load), 32'd0);

    // 5: reset after 10 bits of a frame, then FFFF loads cleanly
    send_bits(10);
    rst = 1'b1;
    sof = 1'b0; sdi = 1'b1; vld = 1'b1;
    tick();
    rst = 1'b0; vld = 1'b0;
    chk("t5_d", 32'(bus_m.d), 32'h0);
    chk("t5_busy", 32'(bus_m.busy), 32'd0);
    chk("t5_load", 32'(bus_m.load), 32'd0);
    chk("t5_errcnt", 32'(bus_m.err_cnt), 32'd0);
    send_word(16'hFFFF, 0);
    chk("t5_load2", 32'(bus_m.load), 32'd1);
    chk("t5_d2", 32'(bus_m.d), 32'h0000FFFF);

    // Back-to-back: new frame starts the cycle after completion
    base_load = load_seen;
    send_word(16'h1234, 0);
    chk("b2b_load", 32'(bus_m.load), 32'd1);
    chk("b2b_d", 32'(bus_m.d), 32'h00001234);
    send_word(16'h8000, 0);

    // 6: single leading one, bit order per instance
    chk("t6_d_msb", 32'(bus_m.d), 32'h00008000);
    chk("t6_d_lsb", 32'(bus_l.d), 32'h00000001);
    chk("t6_loads", 32'(load_seen - base_load), 32'd2);
    idle(1);

    // 6: 300 early-sof aborts saturate err_cnt
    sof = 1'b1; sdi = 1'b0; vld = 1'b1;
    tick();
    chk("t6_first_sof", 32'(bus_m.err), 32'd0);
    for (int i = 0; i < 254; i++) tick();
    chk("t6_cnt_254", 32'(bus_m.err_cnt), 32'h000000FE);
    tick();
    chk("t6_cnt_255", 32'(bus_m.err_cnt), 32'h000000FF);
    for (int i = 0; i < 45; i++) tick();
    chk("t6_sat_msb", 32'(bus_m.err_cnt), 32'h000000FF);
    chk("t6_sat_lsb", 32'(bus_l.err_cnt), 32'h000000FF);
    chk("t6_err_still", 32'(bus_m.err), 32'd1);
    chk("t6_noload", 32'(bus_m.load), 32'd0);
    idle(2);
    chk("t6_err_off", 32'(bus_m.err), 32'd0);
    chk("load_err_overlap", 32'(both_seen), 32'd0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
